// File: rtl/interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl
//   Machine-mode interrupt controller. It decides when to take a timer or
//   external interrupt, saves the trap PC in mepc, and drives a one-cycle
//   redirect pulse to pipeline control on trap entry and on mret. It also
//   owns the trap CSRs (mstatus, mie, mtvec, mepc, mcause, mip).
//
// Configuration macro:
//   IRQ_SYNC_EN - when defined, irq_in and timer_irq_in each pass through a
//                 2-flop synchronizer before reaching mip.
//
// Ports:
//   clk_in           - clock
//   reset_in         - synchronous, active-high reset
//   irq_in           - external interrupt lines, level, active-high
//   timer_irq_in     - timer interrupt, level, active-high
//   mret_in          - one-cycle pulse, mret executed in exe
//   stall_in         - pipeline stalled, defers trap entry only
//   pc_of_epc_in     - trap return PC supplied by pipeline control
//   csr_we_in        - CSR write strobe
//   csr_addr_in      - CSR address for read and write
//   csr_wdata_in     - CSR write data
//   csr_rdata_out    - combinational CSR read data, 0 for unmapped addresses
//   interrupt_en_out - one-cycle redirect/flush pulse
//   isr_pc_out       - redirect target, valid while interrupt_en_out is high
// ---------------------------------------------------------------------------
module interrupt_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    IRQ_NUM     = 4,
  parameter logic [ADDR_WIDTH-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [IRQ_NUM-1:0]    irq_in,
  input  logic                  timer_irq_in,
  input  logic                  mret_in,
  input  logic                  stall_in,
  input  logic [ADDR_WIDTH-1:0] pc_of_epc_in,
  input  logic                  csr_we_in,
  input  logic [11:0]           csr_addr_in,
  input  logic [ADDR_WIDTH-1:0] csr_wdata_in,
  output logic [ADDR_WIDTH-1:0] csr_rdata_out,
  output logic                  interrupt_en_out,
  output logic [ADDR_WIDTH-1:0] isr_pc_out
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int                CODE_W        = 8;
  localparam logic [CODE_W-1:0] CODE_TIMER    = 8'd7;
  localparam logic [CODE_W-1:0] CODE_EXT_BASE = 8'd16;

  // Writable bits of mie: MTIE plus one enable per external line.
  function automatic logic [ADDR_WIDTH-1:0] f_mie_mask();
    logic [ADDR_WIDTH-1:0] m;
    m                = '0;
    m[7]             = 1'b1;
    m[16 +: IRQ_NUM] = {IRQ_NUM{1'b1}};
    return m;
  endfunction

  localparam logic [ADDR_WIDTH-1:0] MIE_MASK = f_mie_mask();

  // Winning cause code: timer first, then the lowest-index external line.
  function automatic logic [CODE_W-1:0] f_prio(input logic [ADDR_WIDTH-1:0] pend);
    logic [CODE_W-1:0] code;
    code = CODE_TIMER;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (pend[16 + i]) begin
        code = CODE_EXT_BASE + CODE_W'(i);
      end else begin
        code = code;
      end
    end
    if (pend[7]) begin
      code = CODE_TIMER;
    end else begin
      code = code;
    end
    return code;
  endfunction

  // Trap entry target; vectored mode adds 4*code, wrapping at ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] f_target(input logic [ADDR_WIDTH-1:0] tvec,
                                                     input logic [CODE_W-1:0]     code);
    logic [ADDR_WIDTH-1:0] base;
    base = {tvec[ADDR_WIDTH-1:2], 2'b00};
    if (tvec[1:0] == 2'b01) begin
      return base + (ADDR_WIDTH'(code) << 2);
    end else begin
      return base;
    end
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TAKE = 2'b01,
    ST_RET  = 2'b10
  } state_t;

  state_t                r_state;
  logic [CODE_W-1:0]     r_code;
  logic                  r_int_en;
  logic [ADDR_WIDTH-1:0] r_isr_pc;

  logic                  r_mie_bit;
  logic                  r_mpie;
  logic [ADDR_WIDTH-1:0] r_mie;
  logic [ADDR_WIDTH-1:0] r_mtvec;
  logic [ADDR_WIDTH-1:0] r_mepc;
  logic [ADDR_WIDTH-1:0] r_mcause;

  logic [IRQ_NUM-1:0]    w_irq_src;
  logic                  w_tmr_src;
  logic [ADDR_WIDTH-1:0] w_mip;
  logic [ADDR_WIDTH-1:0] w_pend;
  logic [CODE_W-1:0]     w_code;
  logic                  w_take;

  logic                  w_mie_bit_nxt;
  logic                  w_mpie_nxt;
  logic [ADDR_WIDTH-1:0] w_mie_nxt;
  logic [ADDR_WIDTH-1:0] w_mtvec_nxt;
  logic [ADDR_WIDTH-1:0] w_mepc_nxt;
  logic [ADDR_WIDTH-1:0] w_mcause_nxt;

`ifdef IRQ_SYNC_EN
  logic [IRQ_NUM-1:0] r_irq_meta;
  logic [IRQ_NUM-1:0] r_irq_sync;
  logic               r_tmr_meta;
  logic               r_tmr_sync;

  // Two-flop synchronizers for the asynchronous interrupt sources.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_irq_meta <= '0;
      r_irq_sync <= '0;
      r_tmr_meta <= 1'b0;
      r_tmr_sync <= 1'b0;
    end else begin
      r_irq_meta <= irq_in;
      r_irq_sync <= r_irq_meta;
      r_tmr_meta <= timer_irq_in;
      r_tmr_sync <= r_tmr_meta;
    end
  end

  assign w_irq_src = r_irq_sync;
  assign w_tmr_src = r_tmr_sync;
`else
  assign w_irq_src = irq_in;
  assign w_tmr_src = timer_irq_in;
`endif

  // Live pending bits laid out like mie, and the enabled subset.
  always_comb begin
    w_mip                = '0;
    w_mip[7]             = w_tmr_src;
    w_mip[16 +: IRQ_NUM] = w_irq_src;
    w_pend               = w_mip & r_mie;
    w_code               = f_prio(w_pend);
    // mret wins over a simultaneous interrupt; the interrupt is retried later.
    w_take               = r_mie_bit && (w_pend != '0) && !stall_in && !mret_in;
  end

  // Next CSR values: software writes first, then hardware updates of
  // TAKE/RET override them, which drops a colliding software write.
  always_comb begin
    w_mie_bit_nxt = r_mie_bit;
    w_mpie_nxt    = r_mpie;
    w_mie_nxt     = r_mie;
    w_mtvec_nxt   = r_mtvec;
    w_mepc_nxt    = r_mepc;
    w_mcause_nxt  = r_mcause;
    if (csr_we_in) begin
      case (csr_addr_in)
        CSR_MSTATUS: begin
          w_mie_bit_nxt = csr_wdata_in[3];
          w_mpie_nxt    = csr_wdata_in[7];
        end
        CSR_MIE:    w_mie_nxt    = csr_wdata_in & MIE_MASK;
        CSR_MTVEC:  w_mtvec_nxt  = csr_wdata_in;
        CSR_MEPC:   w_mepc_nxt   = {csr_wdata_in[ADDR_WIDTH-1:2], 2'b00};
        CSR_MCAUSE: w_mcause_nxt = csr_wdata_in;
        default: begin
        end
      endcase
    end else begin
      w_mie_nxt = r_mie;
    end
    case (r_state)
      ST_TAKE: begin
        w_mepc_nxt    = {pc_of_epc_in[ADDR_WIDTH-1:2], 2'b00};
        w_mcause_nxt  = {1'b1, {(ADDR_WIDTH-1-CODE_W){1'b0}}, r_code};
        w_mpie_nxt    = r_mie_bit;
        w_mie_bit_nxt = 1'b0;
      end
      ST_RET: begin
        w_mie_bit_nxt = r_mpie;
        w_mpie_nxt    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Trap FSM, CSR state and registered redirect outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state   <= ST_IDLE;
      r_code    <= '0;
      r_int_en  <= 1'b0;
      r_isr_pc  <= '0;
      r_mie_bit <= 1'b0;
      r_mpie    <= 1'b0;
      r_mie     <= '0;
      r_mtvec   <= MTVEC_RESET;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else begin
      r_mie_bit <= w_mie_bit_nxt;
      r_mpie    <= w_mpie_nxt;
      r_mie     <= w_mie_nxt;
      r_mtvec   <= w_mtvec_nxt;
      r_mepc    <= w_mepc_nxt;
      r_mcause  <= w_mcause_nxt;
      case (r_state)
        ST_IDLE: begin
          if (mret_in) begin
            r_state  <= ST_RET;
            r_int_en <= 1'b1;
            r_isr_pc <= w_mepc_nxt;
          end else if (w_take) begin
            r_state  <= ST_TAKE;
            r_code   <= w_code;
            r_int_en <= 1'b1;
            r_isr_pc <= f_target(w_mtvec_nxt, w_code);
          end else begin
            r_int_en <= 1'b0;
            r_isr_pc <= '0;
          end
        end
        // TAKE and RET last one cycle and ignore stall_in.
        ST_TAKE, ST_RET: begin
          r_state  <= ST_IDLE;
          r_int_en <= 1'b0;
          r_isr_pc <= '0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_int_en <= 1'b0;
          r_isr_pc <= '0;
        end
      endcase
    end
  end

  // CSR read mux; mip shows the live sources.
  always_comb begin
    csr_rdata_out = '0;
    case (csr_addr_in)
      CSR_MSTATUS: begin
        csr_rdata_out[3] = r_mie_bit;
        csr_rdata_out[7] = r_mpie;
      end
      CSR_MIE:    csr_rdata_out = r_mie;
      CSR_MTVEC:  csr_rdata_out = r_mtvec;
      CSR_MEPC:   csr_rdata_out = r_mepc;
      CSR_MCAUSE: csr_rdata_out = r_mcause;
      CSR_MIP:    csr_rdata_out = w_mip;
      default:    csr_rdata_out = '0;
    endcase
  end

  assign interrupt_en_out = r_int_en;
  assign isr_pc_out       = r_isr_pc;

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic [3:0]  irq_in = 4'b0000;
  logic        timer_irq_in = 1'b0;
  logic        mret_in = 1'b0;
  logic        stall_in = 1'b0;
  logic [31:0] pc_of_epc_in = 32'h0;
  logic        csr_we_in = 1'b0;
  logic [11:0] csr_addr_in = 12'h000;
  logic [31:0] csr_wdata_in = 32'h0;
  logic [31:0] csr_rdata_out;
  logic        interrupt_en_out;
  logic [31:0] isr_pc_out;

  int vectors = 0;
  int miscompares = 0;

  interrupt_ctrl dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .irq_in          (irq_in),
    .timer_irq_in    (timer_irq_in),
    .mret_in         (mret_in),
    .stall_in        (stall_in),
    .pc_of_epc_in    (pc_of_epc_in),
    .csr_we_in       (csr_we_in),
    .csr_addr_in     (csr_addr_in),
    .csr_wdata_in    (csr_wdata_in),
    .csr_rdata_out   (csr_rdata_out),
    .interrupt_en_out(interrupt_en_out),
    .isr_pc_out      (isr_pc_out)
  );

  always #5 clk = ~clk;

  // Architectural reference state.
  bit          m_mie_bit = 1'b0;
  bit          m_mpie    = 1'b0;
  logic [31:0] m_mie     = 32'h0;
  logic [31:0] m_mtvec   = 32'h0000_0100;
  logic [31:0] m_mepc    = 32'h0;
  logic [31:0] m_mcause  = 32'h0;
  int          m_pulse   = 0;   // 0: none, 1: trap entry in flight, 2: return in flight
  int          m_code    = 0;
  bit          exp_en    = 1'b0;
  logic [31:0] exp_pc    = 32'h0;
  bit          last_reset = 1'b0;

  function automatic logic [31:0] mip_now();
    return ({31'h0, timer_irq_in} << 7) | ({28'h0, irq_in} << 16);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return ({31'h0, m_mpie} << 7) | ({31'h0, m_mie_bit} << 3);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return mip_now();
      default: return 32'h0;
    endcase
  endfunction

  function automatic int prio(input logic [31:0] pend);
    if (pend[7]) return 7;
    for (int i = 0; i < 4; i++) if (pend[16 + i]) return 16 + i;
    return 0;
  endfunction

  // Advance the reference across one clock edge using the current inputs.
  task automatic model_step();
    logic [31:0] pend;
    bit old_mie;
    bit old_mpie;
    if (reset_in) begin
      m_mie_bit = 1'b0; m_mpie = 1'b0; m_mie = 32'h0; m_mtvec = 32'h0000_0100;
      m_mepc = 32'h0; m_mcause = 32'h0; m_pulse = 0;
      exp_en = 1'b0; exp_pc = 32'h0; last_reset = 1'b1;
      return;
    end
    last_reset = 1'b0;
    pend     = mip_now() & m_mie;
    old_mie  = m_mie_bit;
    old_mpie = m_mpie;
    if (csr_we_in) begin
      case (csr_addr_in)
        12'h300: begin m_mie_bit = csr_wdata_in[3]; m_mpie = csr_wdata_in[7]; end
        12'h304: m_mie = csr_wdata_in & 32'h000F_0080;
        12'h305: m_mtvec = csr_wdata_in;
        12'h341: m_mepc = csr_wdata_in & 32'hFFFF_FFFC;
        12'h342: m_mcause = csr_wdata_in;
        default: ;
      endcase
    end
    if (m_pulse == 1) begin
      m_mepc = pc_of_epc_in & 32'hFFFF_FFFC;
      m_mcause = 32'h8000_0000 + 32'(m_code);
      m_mpie = old_mie;
      m_mie_bit = 1'b0;
    end else if (m_pulse == 2) begin
      m_mie_bit = old_mpie;
      m_mpie = 1'b1;
    end
    if (m_pulse != 0) begin
      m_pulse = 0; exp_en = 1'b0;
    end else if (mret_in) begin
      m_pulse = 2; exp_en = 1'b1; exp_pc = m_mepc;
    end else if (old_mie && pend != 32'h0 && !stall_in) begin
      m_code = prio(pend);
      m_pulse = 1; exp_en = 1'b1;
      exp_pc = (m_mtvec & 32'hFFFF_FFFC) + ((m_mtvec[1:0] == 2'b01) ? 32'(4 * m_code) : 32'h0);
    end else begin
      exp_en = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check read data, step the model, cross the edge, check outputs.
  task automatic tick();
    #1;
    chk("csr_rdata", csr_rdata_out, model_read(csr_addr_in));
    model_step();
    @(posedge clk);
    #1;
    chk("int_en", {31'h0, interrupt_en_out}, {31'h0, exp_en});
    if (exp_en || last_reset) chk("isr_pc", isr_pc_out, exp_pc);
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e);
    csr_addr_in = a;
    #1;
    chk(tag, csr_rdata_out, e);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_in = 1'b1; csr_addr_in = a; csr_wdata_in = d;
    tick();
    csr_we_in = 1'b0;
  endtask

  initial begin
    logic [11:0] addrs [7];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h123};
    @(posedge clk); #1;
    tick();
    reset_in = 1'b0;
    rd("rst_mtvec", 12'h305, 32'h0000_0100);
    rd("rst_mstatus", 12'h300, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);
    chk("rst_en", {31'h0, interrupt_en_out}, 32'h0);
    chk("rst_pc", isr_pc_out, 32'h0);

    // Timer interrupt, direct mode.
    wr(12'h305, 32'h200); wr(12'h304, 32'h80); wr(12'h300, 32'h8);
    timer_irq_in = 1'b1; pc_of_epc_in = 32'h1234;
    tick();
    chk("timer_en", {31'h0, interrupt_en_out}, 32'h1);
    chk("timer_pc", isr_pc_out, 32'h200);
    timer_irq_in = 1'b0;
    tick();
    chk("timer_single", {31'h0, interrupt_en_out}, 32'h0);
    rd("timer_mepc", 12'h341, 32'h1234);
    rd("timer_mcause", 12'h342, 32'h8000_0007);
    rd("timer_mstatus", 12'h300, 32'h80);

    // mret returns to mepc.
    mret_in = 1'b1; tick();
    chk("mret_pc", isr_pc_out, 32'h1234);
    mret_in = 1'b0; tick();
    rd("mret_mstatus", 12'h300, 32'h88);

    // Vectored external interrupts and priority.
    wr(12'h305, 32'h201); wr(12'h304, 32'h0005_0000);
    irq_in = 4'b0101; tick();
    chk("vec0_pc", isr_pc_out, 32'h240);
    tick();
    rd("vec0_mcause", 12'h342, 32'h8000_0010);
    irq_in = 4'b0100; mret_in = 1'b1; tick();
    mret_in = 1'b0; tick();
    tick();
    chk("vec2_en", {31'h0, interrupt_en_out}, 32'h1);
    chk("vec2_pc", isr_pc_out, 32'h248);
    tick();
    rd("vec2_mcause", 12'h342, 32'h8000_0012);

    // Stall defers entry.
    irq_in = 4'b0000; mret_in = 1'b1; tick();
    mret_in = 1'b0; tick();
    stall_in = 1'b1; irq_in = 4'b0001; pc_of_epc_in = 32'h5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {31'h0, interrupt_en_out}, 32'h0);
    end
    stall_in = 1'b0; tick();
    chk("stall_release", {31'h0, interrupt_en_out}, 32'h1);
    tick();

    // mret wins over a pending interrupt, which follows two cycles later.
    mret_in = 1'b1; tick();
    chk("both_ret_en", {31'h0, interrupt_en_out}, 32'h1);
    chk("both_ret_pc", isr_pc_out, 32'h5678);
    mret_in = 1'b0; tick();
    chk("both_gap", {31'h0, interrupt_en_out}, 32'h0);
    tick();
    chk("both_take_en", {31'h0, interrupt_en_out}, 32'h1);
    chk("both_take_pc", isr_pc_out, 32'h240);

    // Reset while in TAKE.
    reset_in = 1'b1; irq_in = 4'b0000; tick();
    chk("rst_take_en", {31'h0, interrupt_en_out}, 32'h0);
    reset_in = 1'b0;
    rd("rst_take_mtvec", 12'h305, 32'h100);
    rd("rst_take_mepc", 12'h341, 32'h0);
    rd("rst_take_mstatus", 12'h300, 32'h0);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      reset_in = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) timer_irq_in = 1'($urandom_range(0, 1));
      mret_in  = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 3) == 0);
      pc_of_epc_in = $urandom;
      csr_we_in = ($urandom_range(0, 2) == 0);
      csr_addr_in = addrs[$urandom_range(0, 6)];
      csr_wdata_in = $urandom;
      if (csr_addr_in == 12'h300 && $urandom_range(0, 1) == 1) csr_wdata_in[3] = 1'b1;
      tick();
    end
    reset_in = 1'b0; csr_we_in = 1'b0; mret_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Machine-mode interrupt controller. Sits between the external/timer interrupt sources and the pipeline control block.
- Decides when to take an interrupt and saves the trap PC supplied by pipeline control into mepc.
- Drives the one-cycle interrupt redirect (interrupt_en_out, isr_pc_out) that pipeline control uses to flush and load a new PC, both on trap entry and on mret.
- Owns the trap CSRs, accessed through a simple read/write port from the execute stage.

Parameters:
- ADDR_WIDTH, 32, width of PC and CSR data.
- IRQ_NUM, 4, number of external level-sensitive interrupt lines.
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec.

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  synchronous, active-high reset.
- irq_in  input  IRQ_NUM  external interrupt lines, level, active-high.
- timer_irq_in  input  1  timer interrupt, level, active-high.
- mret_in  input  1  one-cycle pulse: mret executed in exe.
- stall_in  input  1  pipeline stalled; trap entry is deferred.
- pc_of_epc_in  input  ADDR_WIDTH  trap return PC from pipeline control.
- csr_we_in  input  1  CSR write strobe.
- csr_addr_in  input  12  CSR address for read and write.
- csr_wdata_in  input  ADDR_WIDTH  CSR write data.
- csr_rdata_out  output  ADDR_WIDTH  combinational read data; 0 for unmapped addresses.
- interrupt_en_out  output  1  one-cycle redirect/flush pulse.
- isr_pc_out  output  ADDR_WIDTH  redirect target, valid while interrupt_en_out=1.

Behaviour:
- CSRs:
  - mstatus 0x300: bit3 MIE, bit7 MPIE; other bits read 0.
  - mie 0x304: bit7 MTIE, bits[16+IRQ_NUM-1:16] external enables.
  - mtvec 0x305: [1:0] mode, 00 direct, 01 vectored.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: read-only, live pending bits in the same layout as mie; writes ignored.
- Reset values: state IDLE, interrupt_en_out 0, isr_pc_out 0, mstatus 0, mie 0, mtvec MTVEC_RESET, mepc 0, mcause 0.
- Pending: pend = mip & mie.
- Priority: timer (code 7) > irq_in[0] (code 16) > irq_in[1] (code 17) > … The lowest index wins among external lines.
- FSM states: IDLE, TAKE, RET.
  - IDLE -> TAKE: when MIE=1, pend≠0, stall_in=0 and mret_in=0. The winning code is latched at this edge.
  - IDLE -> RET: when mret_in=1. mret has priority over a simultaneous interrupt; the interrupt is re-evaluated after RET.
  - TAKE, for exactly one cycle:
    - interrupt_en_out=1.
    - mepc <= {pc_of_epc_in[ADDR_WIDTH-1:2], 2'b00}.
    - mcause <= {1'b1, latched code}.
    - MPIE <= MIE, MIE <= 0.
    - isr_pc_out = {mtvec[ADDR_WIDTH-1:2], 2'b00}, plus 4*code when mode=01. Addition wraps modulo 2^ADDR_WIDTH.
    - Next state IDLE.
  - RET, for exactly one cycle:
    - interrupt_en_out=1, isr_pc_out=mepc.
    - MIE <= MPIE, MPIE <= 1.
    - Next state IDLE.
- Latency: qualifying pend seen at edge N gives interrupt_en_out high in cycle N+1. mret_in at edge N gives the redirect in cycle N+1.
- interrupt_en_out is registered (a decode of state). It is never high for two consecutive cycles, so a stalled pipeline can never see a stale pulse.
- stall_in only gates IDLE->TAKE. TAKE and RET complete regardless of stall_in.
- A CSR write coinciding with a hardware update in TAKE/RET to the same CSR is dropped; the hardware update wins. Writes to other CSRs in that cycle take effect.
- Nesting cannot occur, because MIE=0 after TAKE.
- A pend that deasserts before evaluation is not taken, since all sources are level-sensitive.
- reset_in mid-TAKE/RET: next cycle is IDLE with all reset values; the pulse ends immediately.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: irq_in and timer_irq_in each pass through a 2-flop synchronizer (reset to 0) before mip. Entry latency grows by 2 cycles (3 cycles from the raw input edge to interrupt_en_out).
- Undefined: inputs feed mip directly; latency as above.

Test Plan:
- Reset, then set mtvec=0x200 (direct), mie=0x80, mstatus=0x8. Assert timer_irq_in with pc_of_epc_in=0x1234 -> one-cycle pulse with isr_pc_out=0x200; mepc=0x1234; mcause=0x8000_0007; mstatus reads 0x80.
- Assert mret_in -> next cycle pulse with isr_pc_out=0x1234; mstatus reads 0x88.
- Vectored mtvec=0x201, mie enables irq 0 and 2. Raise irq_in=4'b0101 -> mcause=0x8000_0010, isr_pc_out=0x240. After mret with irq_in=4'b0100 -> mcause=0x8000_0012, isr_pc_out=0x248.
- Hold stall_in=1 with pend valid for 5 cycles -> no pulse. Release stall_in -> pulse exactly 1 cycle later.
- Same cycle: mret_in=1 and pend valid with MPIE=1 -> RET pulse first (isr_pc_out=mepc), then TAKE pulse 2 cycles later.
- Assert reset_in during TAKE -> interrupt_en_out=0 the next cycle; all CSRs read their reset values (mtvec=0x100).
